pixel_writer: RTL and testbench

//  Sits directly downstream of the pixel address generator: consumes 40-bit pixel_cmd words and performs the memory access.

---
 rtl/pixel_writer.sv | 213 +++++++++++++++++++++
 tb/tb_pixel_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// Pixel memory engine behind the address generator: RMW writes, copy-to-paste, mask setup.
// Optional collision counter compiled in with `define PIXEL_WRITER_COLLISION_EN.
module pixel_writer #(
  parameter int ADDR_W = 20,
  parameter int COLL_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              pixel_cmd_rdy_i,
  input  logic [39:0]       pixel_cmd_i,
  output logic              draw_busy_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [15:0]       mem_rdata_i,
`ifdef PIXEL_WRITER_COLLISION_EN
  input  logic              coll_clr_i,
  output logic [COLL_W-1:0] coll_count_o,
`endif
  input  logic              mem_rvalid_i
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  localparam logic [3:0] CMD_WR         = 4'd1;
  localparam logic [3:0] CMD_WR_M       = 4'd2;
  localparam logic [3:0] CMD_PASTE      = 4'd3;
  localparam logic [3:0] CMD_PASTE_M    = 4'd4;
  localparam logic [3:0] CMD_COPY       = 4'd6;
  localparam logic [3:0] CMD_WR_MASK    = 4'd10;
  localparam logic [3:0] CMD_PASTE_MASK = 4'd11;

  // Illegal bpp codes behave as 16bpp.
  function automatic logic [3:0] norm_code(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd3, 4'd7, 4'd15: norm_code = code;
      default:                       norm_code = 4'd15;
    endcase
  endfunction

  function automatic logic [15:0] low_ones(input logic [3:0] code);
    case (code)
      4'd0:    low_ones = 16'h0001;
      4'd1:    low_ones = 16'h0003;
      4'd3:    low_ones = 16'h000F;
      4'd7:    low_ones = 16'h00FF;
      default: low_ones = 16'hFFFF;
    endcase
  endfunction

  // Pixels are MSB-first, so the field LSB sits at 15 - bitpos - (bpp-1).
  function automatic logic [3:0] lsb_pos(input logic [3:0] code, input logic [3:0] idx);
    logic [3:0] bitpos;
    case (code)
      4'd0:    bitpos = idx;
      4'd1:    bitpos = {idx[2:0], 1'b0};
      4'd3:    bitpos = {idx[1:0], 2'b00};
      4'd7:    bitpos = {idx[0], 3'b000};
      default: bitpos = 4'd0;
    endcase
    lsb_pos = 4'd15 - bitpos - code;
  endfunction

  state_t            state_q;
  logic [3:0]        cmd_q, code_q, idx_q;
  logic [15:0]       src_q, paste_q;
  logic [7:0]        wr_mask_q, paste_mask_q;
  logic              busy_q, req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;

  logic [3:0]  in_cmd, in_code, in_idx;
  logic [7:0]  in_colour;
  logic [15:0] in_src;
  logic        in_write, in_skip;
  logic [3:0]  fld_lsb;
  logic [15:0] fld_mask, rd_field, merged;

  assign in_cmd    = pixel_cmd_i[39:36];
  assign in_colour = pixel_cmd_i[35:28];
  assign in_code   = norm_code(pixel_cmd_i[27:24]);
  assign in_idx    = pixel_cmd_i[23:20];
  assign in_write  = (in_cmd == CMD_WR) || (in_cmd == CMD_WR_M) ||
                     (in_cmd == CMD_PASTE) || (in_cmd == CMD_PASTE_M);
  assign in_src    = (((in_cmd == CMD_PASTE) || (in_cmd == CMD_PASTE_M)) ? paste_q
                      : {8'h00, in_colour}) & low_ones(in_code);
  assign in_skip   = ((in_cmd == CMD_WR_M) && (in_colour == wr_mask_q)) ||
                     ((in_cmd == CMD_PASTE_M) && (paste_q[7:0] == paste_mask_q));

  assign fld_lsb  = lsb_pos(code_q, idx_q);
  assign fld_mask = low_ones(code_q) << fld_lsb;
  assign rd_field = (mem_rdata_i & fld_mask) >> fld_lsb;
  assign merged   = (mem_rdata_i & ~fld_mask) | ((src_q << fld_lsb) & fld_mask);

  // Command FSM with registered memory-side outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      cmd_q        <= 4'd0;
      code_q       <= 4'd0;
      idx_q        <= 4'd0;
      src_q        <= 16'h0000;
      paste_q      <= 16'h0000;
      wr_mask_q    <= 8'h00;
      paste_mask_q <= 8'h00;
      busy_q       <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (pixel_cmd_rdy_i) begin
            cmd_q  <= in_cmd;
            code_q <= in_code;
            idx_q  <= in_idx;
            src_q  <= in_src;
            if (in_write && !in_skip) begin
              busy_q <= 1'b1;
              req_q  <= 1'b1;
              addr_q <= {pixel_cmd_i[ADDR_W-1:1], 1'b0};
              if (in_code == 4'd15) begin
                we_q    <= 1'b1;
                wdata_q <= in_src;
                state_q <= WR_REQ;
              end else begin
                we_q    <= 1'b0;
                state_q <= RD_REQ;
              end
            end else if (in_cmd == CMD_COPY) begin
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= {pixel_cmd_i[ADDR_W-1:1], 1'b0};
              state_q <= RD_REQ;
            end else if (in_cmd == CMD_WR_MASK) begin
              wr_mask_q <= pixel_cmd_i[7:0];
            end else if (in_cmd == CMD_PASTE_MASK) begin
              paste_mask_q <= pixel_cmd_i[7:0];
            end
          end
        end
        RD_REQ: begin
          if (mem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            if (cmd_q == CMD_COPY) begin
              paste_q <= rd_field;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              wdata_q <= merged;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              state_q <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem_ack_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign draw_busy_o = busy_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

`ifdef PIXEL_WRITER_COLLISION_EN
  logic [7:0]        colour_q;
  logic [COLL_W-1:0] coll_q;
  logic              coll_hit;

  assign coll_hit = (state_q == RD_WAIT) && mem_rvalid_i && (cmd_q == CMD_COPY) &&
                    (rd_field != ({8'h00, colour_q} & low_ones(code_q)));

  // Copy-colour capture and saturating collision counter; clear beats increment
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      colour_q <= 8'h00;
      coll_q   <= '0;
    end else begin
      if ((state_q == IDLE) && pixel_cmd_rdy_i) begin
        colour_q <= in_colour;
      end
      if (coll_clr_i) begin
        coll_q <= '0;
      end else if (coll_hit && (coll_q != {COLL_W{1'b1}})) begin
        coll_q <= coll_q + COLL_W'(1);
      end
    end
  end

  assign coll_count_o = coll_q;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: vector table plus stall/reset and collision sequences.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_cmd_rdy;
  logic [39:0] pixel_cmd;
  logic        draw_busy, mem_req, mem_we;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack, mem_rvalid;
`ifdef PIXEL_WRITER_COLLISION_EN
  logic        coll_clr;
  logic [15:0] coll_count;
`endif

  always #5 clk = ~clk;

  pixel_writer dut (
    .clk_i(clk), .reset_n_i(reset_n), .pixel_cmd_rdy_i(pixel_cmd_rdy), .pixel_cmd_i(pixel_cmd),
    .draw_busy_o(draw_busy), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
`ifdef PIXEL_WRITER_COLLISION_EN
    .coll_clr_i(coll_clr), .coll_count_o(coll_count),
`endif
    .mem_rvalid_i(mem_rvalid)
  );

  int checks = 0;
  int errors = 0;

  // memory model state
  logic        ack_en, rv_en, rv_pending;
  logic [15:0] rd_val;
  int          wr_cnt, rd_cnt;
  logic [19:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        s_busy, s_req, s_we;
  logic [19:0] s_addr;
  logic [15:0] s_wdata;

  typedef struct {
    logic [39:0] w;
    logic [15:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [19:0] addr;
    logic [15:0] wdata;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [39:0] mk(input logic [3:0] cmd, input logic [7:0] col,
                                     input logic [3:0] code, input logic [3:0] idx,
                                     input logic [19:0] addr);
    return {cmd, col, code, idx, addr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample outputs and answer at negedge, book-keep the edge, settle.
  task automatic cyc();
    @(negedge clk);
    s_busy = draw_busy; s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    mem_ack    = ack_en && s_req;
    mem_rvalid = rv_en && rv_pending;
    mem_rdata  = mem_rvalid ? rd_val : 16'h0000;
    @(posedge clk);
    if (mem_rvalid) rv_pending = 1'b0;
    if (mem_ack && !s_we) begin rv_pending = 1'b1; rd_cnt++; rd_addr = s_addr; end
    if (mem_ack && s_we) begin wr_cnt++; wr_addr = s_addr; wr_data = s_wdata; end
    #1;
  endtask

  // Latency = accept cycle plus cycles with draw_busy high.
  task automatic run_cmd(input logic [39:0] w, output int lat);
    int n;
    n = 1;
    pixel_cmd = w; pixel_cmd_rdy = 1'b1;
    cyc();
    pixel_cmd_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!s_busy) break;
      n++;
    end
    lat = n;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, s_busy, 1'b0);
    check({tag, "_req"}, s_req, 1'b0);
    check({tag, "_we"}, s_we, 1'b0);
    check({tag, "_addr"}, s_addr, 20'h00000);
    check({tag, "_wdata"}, s_wdata, 16'h0000);
  endtask

  initial begin
    int lat, rd0, wr0;
    reset_n = 1'b0; pixel_cmd_rdy = 1'b0; pixel_cmd = 40'h0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    ack_en = 1'b1; rv_en = 1'b1; rv_pending = 1'b0; rd_val = 16'h0000;
    wr_cnt = 0; rd_cnt = 0; wr_addr = 20'h0; rd_addr = 20'h0; wr_data = 16'h0;
`ifdef PIXEL_WRITER_COLLISION_EN
    coll_clr = 1'b0;
`endif

    //               w                              rdata     lat rd wr addr      wdata
    vecs[0]  = '{mk(4'd1,  8'hA5, 4'hF, 4'd0,  20'h00100), 16'h0000, 2, 0, 1, 20'h00100, 16'h00A5};
    vecs[1]  = '{mk(4'd1,  8'h0C, 4'h3, 4'd2,  20'h00200), 16'h1234, 4, 1, 1, 20'h00200, 16'h12C4};
    vecs[2]  = '{mk(4'd10, 8'h00, 4'h0, 4'd0,  20'h00007), 16'h0000, 1, 0, 0, 20'h00000, 16'h0000};
    vecs[3]  = '{mk(4'd2,  8'h07, 4'h7, 4'd0,  20'h00300), 16'h0000, 1, 0, 0, 20'h00000, 16'h0000};
    vecs[4]  = '{mk(4'd2,  8'h08, 4'h7, 4'd1,  20'h00300), 16'hFFFF, 4, 1, 1, 20'h00300, 16'hFF08};
    vecs[5]  = '{mk(4'd6,  8'h00, 4'h0, 4'd0,  20'h00400), 16'h8000, 3, 1, 0, 20'h00400, 16'h0000};
    vecs[6]  = '{mk(4'd3,  8'h00, 4'h0, 4'd15, 20'h00402), 16'h0000, 4, 1, 1, 20'h00402, 16'h0001};
    vecs[7]  = '{mk(4'd11, 8'h00, 4'h0, 4'd0,  20'h00001), 16'h0000, 1, 0, 0, 20'h00000, 16'h0000};
    vecs[8]  = '{mk(4'd4,  8'h00, 4'hF, 4'd0,  20'h00500), 16'h0000, 1, 0, 0, 20'h00000, 16'h0000};
    vecs[9]  = '{mk(4'd7,  8'hFF, 4'hF, 4'd0,  20'h00600), 16'h0000, 1, 0, 0, 20'h00000, 16'h0000};
    vecs[10] = '{mk(4'd0,  8'hFF, 4'hF, 4'd0,  20'h00600), 16'h0000, 1, 0, 0, 20'h00000, 16'h0000};
    vecs[11] = '{mk(4'd15, 8'hFF, 4'hF, 4'd0,  20'h00600), 16'h0000, 1, 0, 0, 20'h00000, 16'h0000};
    vecs[12] = '{mk(4'd1,  8'h3C, 4'h5, 4'd0,  20'h00701), 16'h0000, 2, 0, 1, 20'h00700, 16'h003C};
    vecs[13] = '{mk(4'd1,  8'hFE, 4'h1, 4'd5,  20'h00800), 16'h0000, 4, 1, 1, 20'h00800, 16'h0020};
    vecs[14] = '{mk(4'd6,  8'h00, 4'h3, 4'd3,  20'h00900), 16'hABCD, 3, 1, 0, 20'h00900, 16'h0000};
    vecs[15] = '{mk(4'd4,  8'h00, 4'hF, 4'd0,  20'h00A00), 16'h0000, 2, 0, 1, 20'h00A00, 16'h000D};
    vecs[16] = '{mk(4'd3,  8'h00, 4'h7, 4'd0,  20'h00B00), 16'h5566, 4, 1, 1, 20'h00B00, 16'h0D66};

    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    check_idle_outputs("reset");

    foreach (vecs[k]) begin
      rd_val = vecs[k].rdata;
      rd0 = rd_cnt; wr0 = wr_cnt;
      run_cmd(vecs[k].w, lat);
      check($sformatf("v%0d_lat", k), lat, vecs[k].lat);
      check($sformatf("v%0d_nrd", k), rd_cnt - rd0, vecs[k].nrd);
      check($sformatf("v%0d_nwr", k), wr_cnt - wr0, vecs[k].nwr);
      if (vecs[k].nrd > 0) check($sformatf("v%0d_rdaddr", k), rd_addr, vecs[k].addr);
      if (vecs[k].nwr > 0) begin
        check($sformatf("v%0d_wraddr", k), wr_addr, vecs[k].addr);
        check($sformatf("v%0d_wdata", k), wr_data, vecs[k].wdata);
      end
    end

    // Commands presented while busy are not taken.
    ack_en = 1'b0; rd_val = 16'h0000; wr0 = wr_cnt;
    pixel_cmd = mk(4'd1, 8'h0C, 4'h3, 4'd2, 20'h00C00); pixel_cmd_rdy = 1'b1;
    cyc();
    pixel_cmd = mk(4'd1, 8'h11, 4'hF, 4'd0, 20'h00D00);
    repeat (3) cyc();
    check("busy_hold_addr", s_addr, 20'h00C00);
    pixel_cmd_rdy = 1'b0; ack_en = 1'b1;
    for (int i = 0; i < 20; i++) begin cyc(); if (!s_busy) break; end
    check("busy_ign_nwr", wr_cnt - wr0, 1);
    check("busy_ign_addr", wr_addr, 20'h00C00);
    check("busy_ign_wdata", wr_data, 16'h00C0);

    // Stalled read request, then reset while waiting for read data.
    ack_en = 1'b0; rv_en = 1'b0; wr0 = wr_cnt; rd_val = 16'hFFFF;
    pixel_cmd = mk(4'd1, 8'h0C, 4'h3, 4'd2, 20'h00E00); pixel_cmd_rdy = 1'b1;
    cyc();
    pixel_cmd_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("stall%0d_req", i), s_req, 1'b1);
      check($sformatf("stall%0d_addr", i), s_addr, 20'h00E00);
    end
    ack_en = 1'b1;
    cyc();
    ack_en = 1'b0;
    cyc();
    check("rdwait_req", s_req, 1'b0);
    check("rdwait_busy", s_busy, 1'b1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1; rv_en = 1'b1; ack_en = 1'b1;
    cyc();
    check("late_rvalid_given", mem_rvalid, 1'b1);
    check_idle_outputs("midrst");
    repeat (4) cyc();
    check_idle_outputs("postrst");
    check("postrst_nwr", wr_cnt - wr0, 0);

    // Paste buffer and write mask were cleared by the reset.
    run_cmd(mk(4'd3, 8'h00, 4'hF, 4'd0, 20'h00F00), lat);
    check("rst_paste_lat", lat, 2);
    check("rst_paste_wdata", wr_data, 16'h0000);
    wr0 = wr_cnt;
    run_cmd(mk(4'd2, 8'h00, 4'hF, 4'd0, 20'h01000), lat);
    check("rst_wrmask_lat", lat, 1);
    check("rst_wrmask_nwr", wr_cnt - wr0, 0);

`ifdef PIXEL_WRITER_COLLISION_EN
    coll_clr = 1'b1; cyc(); coll_clr = 1'b0; cyc();
    check("coll_clr0", coll_count, 16'd0);
    rd_val = 16'h8000; run_cmd(mk(4'd6, 8'h00, 4'h0, 4'd0, 20'h02000), lat);
    rd_val = 16'h0000; run_cmd(mk(4'd6, 8'h00, 4'h0, 4'd0, 20'h02000), lat);
    rd_val = 16'h8000; run_cmd(mk(4'd6, 8'h00, 4'h0, 4'd0, 20'h02000), lat);
    check("coll_count2", coll_count, 16'd2);
    coll_clr = 1'b1; cyc(); coll_clr = 1'b0; cyc();
    check("coll_clr1", coll_count, 16'd0);
    coll_clr = 1'b1; rd_val = 16'h8000;
    run_cmd(mk(4'd6, 8'h00, 4'h0, 4'd0, 20'h02000), lat);
    coll_clr = 1'b0; cyc();
    check("coll_clr_wins", coll_count, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
